// File: rtl/aes_pipe_pkg.sv
// Constants shared by the aes_128 pipeline and the blocks that sit around it.
package aes_pipe_pkg;
  localparam int AES_LATENCY = 25;
  localparam int AES_BLOCK_W = 128;
endpackage

// File: rtl/aes_result_collector_if.sv
// Request/result handshake between the issuing side, the pipeline bus and the result consumer.
interface aes_result_collector_if import aes_pipe_pkg::*; #(
  parameter int DATA_W = AES_BLOCK_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pipe_out;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_valid, pipe_out, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, pipe_out, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_result_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is always visible on rd_data.
module aes_result_fifo import aes_pipe_pkg::*; #(
  parameter  int DEPTH  = 32,
  parameter  int DATA_W = AES_BLOCK_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [LW-1:0]     level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // NOTE: storage is deliberately not reset; rd_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rd_valid = (level != '0);
  assign rd_data  = mem[rd_ptr];

  // Credit accounting upstream guarantees these never fire.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !rd_en && level == LW'(DEPTH)));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(rd_en && level == '0));
endmodule

// File: rtl/aes_result_collector.sv
// Tags results of the flow-control-free aes_128 pipeline with a latency-matched valid
// shift register and hands them to a consumer through a credit-limited FIFO.
module aes_result_collector import aes_pipe_pkg::*; #(
  parameter  int LATENCY = AES_LATENCY,
  parameter  int DEPTH   = 32,
  parameter  int DATA_W  = AES_BLOCK_W,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_result_collector_if.slave  bus,
  output logic [LW-1:0]          level,
  output logic                   drop_err,
  output logic [31:0]            pop_cnt
);
  logic [LATENCY-1:0] vld_sr;
  logic [LW-1:0]      credits;
  logic [LW-1:0]      credits_nxt;
  logic               ready;
  logic               acc;
  logic               pop;
  logic               fifo_valid;

  assign ready = (credits != '0);
  assign acc   = bus.in_valid && ready;
  assign pop   = fifo_valid && bus.out_ready;

  // NOTE: every register below uses non-blocking assignment so all stages update together.
  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[LATENCY-2:0], acc};
  end

  // A credit leaves with each accepted request and returns when its result is popped.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    credits_nxt = credits;
    case ({acc, pop})
      2'b10:   credits_nxt = credits - 1'b1;
      2'b01:   credits_nxt = credits + 1'b1;
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits  <= LW'(DEPTH);
      drop_err <= 1'b0;
      pop_cnt  <= '0;
    end else begin
      credits <= credits_nxt;
      if (bus.in_valid && !ready) drop_err <= 1'b1;
      if (pop)                    pop_cnt  <= pop_cnt + 1'b1;
    end
  end

  aes_result_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (vld_sr[LATENCY-1]),
    .wr_data  (bus.pipe_out),
    .rd_en    (pop),
    .rd_valid (fifo_valid),
    .rd_data  (bus.out_data),
    .level    (level)
  );

  assign bus.in_ready  = ready;
  assign bus.out_valid = fifo_valid;
endmodule

// File: tb/tb_aes_result_collector.sv
// Bench for aes_result_collector: a delay-line model of the pipeline feeds pipe_out, and a
// negedge monitor scores every popped result against a queue filled at issue time.
module tb_aes_result_collector;
  import aes_pipe_pkg::*;

  localparam int LAT   = AES_LATENCY;
  localparam int DEPTH = 32;
  localparam int DW    = AES_BLOCK_W;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [127:0] val_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] level;
  logic          drop_err;
  logic [31:0]   pop_cnt;

  always #5 clk = ~clk;

  aes_result_collector_if #(.DATA_W(DW)) bus();

  aes_result_collector #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .DATA_W  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .drop_err (drop_err),
    .pop_cnt  (pop_cnt)
  );

  // Stand-in for the cipher: any fixed, key-distinct mapping works for ordering checks.
  function automatic logic [DW-1:0] aes_model(input logic [31:0] k);
    return {k, ~k, k ^ 32'h5A5A_5A5A, k + 32'h0123_4567};
  endfunction

  // Free-running pipeline: the key bus carries a new counter value every cycle.
  logic [31:0] key_cnt = 32'h0;
  logic [31:0] dl [LAT];
  int          cyc = 0;

  always @(posedge clk) begin
    key_cnt <= key_cnt + 32'd1;
    cyc     <= cyc + 1;
    dl[0]   <= key_cnt;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end

  assign bus.pipe_out = aes_model(dl[LAT-1]);

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input val_t act, input val_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard and credit model.
  logic [DW-1:0] exp_q [$];
  int            credits_m = DEPTH;
  bit            drop_m = 1'b0;
  bit            armed = 1'b0;
  int            first_pop_cyc = -1;
  int            last_pop_cyc = -1;
  int            pops_seen = 0;
  int            valid_cycles = 0;

  always @(negedge clk) begin
    bit acc_m;
    bit pop_m;
    if (rst) begin
      credits_m = DEPTH;
      drop_m    = 1'b0;
      exp_q.delete();
      armed     = 1'b1;
    end else if (armed) begin
      check("in_ready", val_t'(bus.in_ready), val_t'(credits_m != 0));
      check("drop_err", val_t'(drop_err), val_t'(drop_m));
      check("level_bound", val_t'(level > LW'(DEPTH)), val_t'(0));
      if (bus.out_valid) valid_cycles++;
      acc_m = bus.in_valid && (credits_m != 0);
      pop_m = bus.out_valid && bus.out_ready;
      if (bus.in_valid && credits_m == 0) drop_m = 1'b1;
      if (pop_m) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got %0h, expected no result (cycle %0d)",
                   bus.out_data, cyc);
        end else begin
          check("out_data", val_t'(bus.out_data), val_t'(exp_q.pop_front()));
        end
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops_seen++;
      end
      if (acc_m) exp_q.push_back(aes_model(key_cnt));
      if (acc_m && !pop_m) credits_m--;
      if (pop_m && !acc_m) credits_m++;
    end
  end

  // Advance to 1 time unit after the next (n-th) rising edge.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int s;
    int a;
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_level", val_t'(level), val_t'(0));
    check("rst_pop_cnt", val_t'(pop_cnt), val_t'(0));
    check("rst_out_valid", val_t'(bus.out_valid), val_t'(0));
    check("rst_in_ready", val_t'(bus.in_ready), val_t'(1));
    check("rst_drop_err", val_t'(drop_err), val_t'(0));

    // Single request: first visible 26 cycles after issue
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    t0 = cyc;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 60) begin
      tick();
      n++;
    end
    check("single_latency", val_t'(cyc - t0), val_t'(26));
    tick(3);
    check("single_level", val_t'(level), val_t'(0));
    check("single_pop_cnt", val_t'(pop_cnt), val_t'(1));

    // Streaming: 100 back-to-back requests, one result per cycle
    first_pop_cyc = -1;
    pops_seen     = 0;
    bus.in_valid  = 1'b1;
    s = cyc;
    tick(100);
    bus.in_valid = 1'b0;
    tick(40);
    check("stream_count", val_t'(pops_seen), val_t'(100));
    check("stream_first", val_t'(first_pop_cyc - s), val_t'(26));
    check("stream_span", val_t'(last_pop_cyc - first_pop_cyc), val_t'(99));
    check("stream_pop_cnt", val_t'(pop_cnt), val_t'(101));
    check("stream_level", val_t'(level), val_t'(0));

    // Backpressure: 32 accepts fill the FIFO, level hits 32 at issue+57
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    s = cyc;
    tick(32);
    bus.in_valid = 1'b0;
    check("bp_no_credit", val_t'(bus.in_ready), val_t'(0));
    tick(24);
    check("bp_level_56", val_t'(level), val_t'(31));
    tick();
    check("bp_level_57", val_t'(level), val_t'(32));
    check("bp_no_drop", val_t'(drop_err), val_t'(0));

    // Drop: three requests with no credits are never written
    bus.in_valid = 1'b1;
    tick(3);
    bus.in_valid = 1'b0;
    tick();
    check("drop_set", val_t'(drop_err), val_t'(1));
    tick(30);
    check("drop_level", val_t'(level), val_t'(32));
    check("drop_sticky", val_t'(drop_err), val_t'(1));

    // A single pop returns a credit; the refill write coincides with another pop
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("pulse_in_ready", val_t'(bus.in_ready), val_t'(1));
    check("pulse_level", val_t'(level), val_t'(31));
    bus.in_valid = 1'b1;
    a = cyc;
    tick();
    bus.in_valid = 1'b0;
    check("pulse_credit_used", val_t'(bus.in_ready), val_t'(0));
    tick(24);
    check("pulse_pre_write", val_t'(cyc - a), val_t'(25));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("wr_and_pop_level", val_t'(level), val_t'(31));
    bus.out_ready = 1'b1;
    tick(40);
    check("drain_level", val_t'(level), val_t'(0));
    check("drain_pop_cnt", val_t'(pop_cnt), val_t'(134));
    check("drain_sb_empty", val_t'(exp_q.size()), val_t'(0));

    // Reset mid-flight: in-flight results are discarded
    bus.in_valid = 1'b1;
    tick(10);
    bus.in_valid = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_cycles = 0;
    tick(40);
    check("mid_rst_no_valid", val_t'(valid_cycles), val_t'(0));
    check("mid_rst_pop_cnt", val_t'(pop_cnt), val_t'(0));
    check("mid_rst_drop_err", val_t'(drop_err), val_t'(0));
    check("mid_rst_level", val_t'(level), val_t'(0));

    // Full credit pool restored after reset
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick(32);
    bus.in_valid = 1'b0;
    check("post_rst_credits", val_t'(bus.in_ready), val_t'(0));
    bus.out_ready = 1'b1;
    tick(70);
    check("post_rst_level", val_t'(level), val_t'(0));
    check("post_rst_pop_cnt", val_t'(pop_cnt), val_t'(32));
    check("post_rst_sb_empty", val_t'(exp_q.size()), val_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end
endmodule
